// File: rtl/acc_datapath_pkg.sv
// Shared widths, strobe indices and strobe-decode helpers for the accumulator datapath.
// Pure definitions: no latency, no backpressure.
package acc_datapath_pkg;

    localparam int DATA_W      = 8;
    localparam int PRESC_W     = 8;
    localparam int OPS_W       = 4;
    localparam int NUM_STROBES = 6;

    localparam int S0_IDX = 0;
    localparam int S1_IDX = 1;
    localparam int S2_IDX = 2;
    localparam int S3_IDX = 3;
    localparam int S4_IDX = 4;
    localparam int S5_IDX = 5;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INIT,
        OP_LOAD,
        OP_ADD,
        OP_COMMIT,
        OP_PUBLISH,
        OP_CLOSE
    } op_e;

    // Lowest strobe index wins, so S0 (init) can always pull the datapath back.
    function automatic op_e pick_op(input logic [NUM_STROBES-1:0] s);
        op_e op;
        op = OP_NONE;
        if      (s[S0_IDX]) op = OP_INIT;
        else if (s[S1_IDX]) op = OP_LOAD;
        else if (s[S2_IDX]) op = OP_ADD;
        else if (s[S3_IDX]) op = OP_COMMIT;
        else if (s[S4_IDX]) op = OP_PUBLISH;
        else if (s[S5_IDX]) op = OP_CLOSE;
        return op;
    endfunction

    function automatic logic multi_hot(input logic [NUM_STROBES-1:0] s);
        return (s & (s - NUM_STROBES'(1))) != '0;
    endfunction

endpackage

// File: rtl/acc_datapath_tick_prescaler.sv
// Free-running prescaler: registered one-cycle OVERFLOW every PERIOD+1 cycles.
// Latency: tick registered one cycle after CNT >= PERIOD; no backpressure, never stalls.
module tick_prescaler
    import acc_datapath_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [PRESC_W-1:0] PERIOD,
    output logic               OVERFLOW
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    // >= rather than == so a PERIOD lowered below CNT ticks at once instead of wrapping.
    always_comb begin
        ovf_d = (cnt_q >= PERIOD);
        cnt_d = ovf_d ? '0 : cnt_q + PRESC_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign OVERFLOW = ovf_q;

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath driven by one-hot controller strobes S0..S5, plus prescaler tick.
// Latency: every strobe acts at the next edge (S1->DOUT is 4 cycles); no backpressure.
module acc_datapath
    import acc_datapath_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               S0,
    input  logic               S1,
    input  logic               S2,
    input  logic               S3,
    input  logic               S4,
    input  logic               S5,
    input  logic               CLR,
    input  logic [DATA_W-1:0]  DIN,
    input  logic [PRESC_W-1:0] PERIOD,
    output logic               OVERFLOW,
    output logic [DATA_W-1:0]  ACC,
    output logic [DATA_W-1:0]  DOUT,
    output logic               CARRY,
    output logic               DONE,
    output logic [OPS_W-1:0]   OPS,
    output logic               STROBE_ERR
);

    logic [NUM_STROBES-1:0] strobes;
    op_e                    op;
    logic [DATA_W:0]        sum;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic              c_q, c_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [OPS_W-1:0]  ops_q, ops_d;
    logic              done_q, done_d;
    logic              serr_q, serr_d;

    tick_prescaler u_presc (
        .CLK      (CLK),
        .RESET    (RESET),
        .PERIOD   (PERIOD),
        .OVERFLOW (OVERFLOW)
    );

    assign strobes = {S5, S4, S3, S2, S1, S0};
    assign op      = pick_op(strobes);
    assign sum     = {1'b0, acc_q} + {1'b0, b_q};

    always_comb begin
        acc_d   = acc_q;
        b_d     = b_q;
        t_d     = t_q;
        c_d     = c_q;
        carry_d = carry_q;
        dout_d  = dout_q;
        ops_d   = ops_q;
        done_d  = 1'b0;
        // A multi-hot cycle that includes S0 still flags the error.
        serr_d  = multi_hot(strobes) | (serr_q & ~S0);

        case (op)
            OP_INIT: begin
                acc_d   = '0;
                b_d     = '0;
                t_d     = '0;
                c_d     = 1'b0;
                carry_d = 1'b0;
                dout_d  = '0;
                ops_d   = '0;
            end
            OP_LOAD:    b_d = DIN;
            OP_ADD:     {c_d, t_d} = sum;
            OP_COMMIT: begin
                acc_d   = t_q;
                carry_d = carry_q | c_q;
            end
            OP_PUBLISH: begin
                dout_d = acc_q;
                done_d = 1'b1;
            end
            OP_CLOSE: begin
                if (CLR) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
                if (ops_q != '1) ops_d = ops_q + OPS_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_q   <= '0;
            b_q     <= '0;
            t_q     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            dout_q  <= '0;
            ops_q   <= '0;
            done_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            b_q     <= b_d;
            t_q     <= t_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            dout_q  <= dout_d;
            ops_q   <= ops_d;
            done_q  <= done_d;
            serr_q  <= serr_d;
        end
    end

    assign ACC        = acc_q;
    assign DOUT       = dout_q;
    assign CARRY      = carry_q;
    assign DONE       = done_q;
    assign OPS        = ops_q;
    assign STROBE_ERR = serr_q;

endmodule
